// File: rtl/id_ex_pkg.sv
// rtl/id_ex_pkg.sv - ID/EX control field widths, bit indices and bubble constants.
package id_ex_pkg;
  localparam int EX_W  = 9;
  localparam int M_W   = 5;
  localparam int WB_W  = 4;
  localparam int REG_W = 5;

  localparam int EX_SHSB_LO   = 7;
  localparam int EX_ALUOP_LO  = 3;
  localparam int EX_ALUSRC    = 2;
  localparam int EX_REGDST_LO = 0;

  localparam int M_BRANCH     = 4;
  localparam int M_MEMREAD    = 3;
  localparam int M_MEMWRITE   = 2;
  localparam int M_SPECBRANCH = 1;
  localparam int M_BNE        = 0;

  localparam int WB_LBLH        = 3;
  localparam int WB_MEMTOREG_LO = 1;
  localparam int WB_REGWRITE    = 0;

  localparam logic [EX_W-1:0] EX_NOP = '0;
  localparam logic [M_W-1:0]  M_NOP  = '0;
  localparam logic [WB_W-1:0] WB_NOP = '0;

  typedef struct packed {
    logic [EX_W-1:0] ex;
    logic [M_W-1:0]  m;
    logic [WB_W-1:0] wb;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{ex: EX_NOP, m: M_NOP, wb: WB_NOP};

  function automatic logic is_mem_read(input ctrl_t c);
    return c.m[M_MEMREAD];
  endfunction
endpackage

// File: rtl/id_ex_register_if.sv
// rtl/id_ex_register_if.sv - decode-to-execute bus; HazardStall/HazardCount exist only with HAZARD_DETECT_EN.
interface id_ex_register_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  import id_ex_pkg::*;

  logic              Stall;
  logic              Flush;
  logic [EX_W-1:0]   EX_in;
  logic [M_W-1:0]    M_in;
  logic [WB_W-1:0]   WB_in;
  logic [DATA_W-1:0] PCPlus4_in;
  logic [DATA_W-1:0] ReadData1_in;
  logic [DATA_W-1:0] ReadData2_in;
  logic [DATA_W-1:0] Imm_in;
  logic [REG_W-1:0]  Rs_in;
  logic [REG_W-1:0]  Rt_in;
  logic [REG_W-1:0]  Rd_in;

  logic [EX_W-1:0]   EX_out;
  logic [M_W-1:0]    M_out;
  logic [WB_W-1:0]   WB_out;
  logic [DATA_W-1:0] PCPlus4_out;
  logic [DATA_W-1:0] ReadData1_out;
  logic [DATA_W-1:0] ReadData2_out;
  logic [DATA_W-1:0] Imm_out;
  logic [REG_W-1:0]  Rs_out;
  logic [REG_W-1:0]  Rt_out;
  logic [REG_W-1:0]  Rd_out;
  logic              Valid_out;
`ifdef HAZARD_DETECT_EN
  logic              HazardStall;
  logic [CNT_W-1:0]  HazardCount;
`endif

  modport master (
    output Stall, Flush, EX_in, M_in, WB_in, PCPlus4_in, ReadData1_in, ReadData2_in,
           Imm_in, Rs_in, Rt_in, Rd_in,
`ifdef HAZARD_DETECT_EN
    input  HazardStall, HazardCount,
`endif
    input  EX_out, M_out, WB_out, PCPlus4_out, ReadData1_out, ReadData2_out, Imm_out,
           Rs_out, Rt_out, Rd_out, Valid_out
  );

  modport slave (
    input  Stall, Flush, EX_in, M_in, WB_in, PCPlus4_in, ReadData1_in, ReadData2_in,
           Imm_in, Rs_in, Rt_in, Rd_in,
`ifdef HAZARD_DETECT_EN
    output HazardStall, HazardCount,
`endif
    output EX_out, M_out, WB_out, PCPlus4_out, ReadData1_out, ReadData2_out, Imm_out,
           Rs_out, Rt_out, Rd_out, Valid_out
  );
endinterface

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - load-use hazard detector with saturating bubble counter.
module load_use_detect
  import id_ex_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             valid_i,
  input  logic             mem_read_i,
  input  logic [REG_W-1:0] rt_ex_i,
  input  logic [REG_W-1:0] rs_id_i,
  input  logic [REG_W-1:0] rt_id_i,
  input  logic             stall_i,
  input  logic             flush_i,
  output logic             hazard_o,
  output logic [CNT_W-1:0] count_o
);
  logic [CNT_W-1:0] count_q, count_d;

  assign hazard_o = valid_i & mem_read_i & (rt_ex_i != '0) &
                    ((rt_ex_i == rs_id_i) | (rt_ex_i == rt_id_i));

  // Only bubbles caused by the hazard itself are counted; flush/stall take precedence.
  always_comb begin
    count_d = count_q;
    if (hazard_o && !stall_i && !flush_i && (count_q != '1)) begin
      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
endmodule

// File: rtl/id_ex_register.sv
// rtl/id_ex_register.sv - ID/EX pipeline register with flush/stall; load-use detection under HAZARD_DETECT_EN.
module id_ex_register
  import id_ex_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic            Clk,
  input  logic            Rst,
  id_ex_register_if.slave bus
);
  ctrl_t             ctrl_q, ctrl_d;
  logic [DATA_W-1:0] pc4_q, pc4_d, rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
  logic [REG_W-1:0]  rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  logic              valid_q, valid_d;
  logic              hazard;

`ifdef HAZARD_DETECT_EN
  logic [CNT_W-1:0] haz_count;

  load_use_detect #(.CNT_W(CNT_W)) u_load_use_detect (
    .Clk        (Clk),
    .Rst        (Rst),
    .valid_i    (valid_q),
    .mem_read_i (is_mem_read(ctrl_q)),
    .rt_ex_i    (rt_q),
    .rs_id_i    (bus.Rs_in),
    .rt_id_i    (bus.Rt_in),
    .stall_i    (bus.Stall),
    .flush_i    (bus.Flush),
    .hazard_o   (hazard),
    .count_o    (haz_count)
  );

  assign bus.HazardStall = hazard;
  assign bus.HazardCount = haz_count;
`else
  assign hazard = 1'b0;
`endif

  // Flush beats Stall, and Stall beats the hazard bubble.
  always_comb begin
    ctrl_d  = '{ex: bus.EX_in, m: bus.M_in, wb: bus.WB_in};
    pc4_d   = bus.PCPlus4_in;
    rd1_d   = bus.ReadData1_in;
    rd2_d   = bus.ReadData2_in;
    imm_d   = bus.Imm_in;
    rs_d    = bus.Rs_in;
    rt_d    = bus.Rt_in;
    rd_d    = bus.Rd_in;
    valid_d = 1'b1;
    if (bus.Flush || (!bus.Stall && hazard)) begin
      ctrl_d  = CTRL_NOP;
      pc4_d   = '0;
      rd1_d   = '0;
      rd2_d   = '0;
      imm_d   = '0;
      rs_d    = '0;
      rt_d    = '0;
      rd_d    = '0;
      valid_d = 1'b0;
    end else if (bus.Stall) begin
      ctrl_d  = ctrl_q;
      pc4_d   = pc4_q;
      rd1_d   = rd1_q;
      rd2_d   = rd2_q;
      imm_d   = imm_q;
      rs_d    = rs_q;
      rt_d    = rt_q;
      rd_d    = rd_q;
      valid_d = valid_q;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      ctrl_q  <= CTRL_NOP;
      pc4_q   <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      imm_q   <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      pc4_q   <= pc4_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      imm_q   <= imm_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      rd_q    <= rd_d;
      valid_q <= valid_d;
    end
  end

  assign bus.EX_out        = ctrl_q.ex;
  assign bus.M_out         = ctrl_q.m;
  assign bus.WB_out        = ctrl_q.wb;
  assign bus.PCPlus4_out   = pc4_q;
  assign bus.ReadData1_out = rd1_q;
  assign bus.ReadData2_out = rd2_q;
  assign bus.Imm_out       = imm_q;
  assign bus.Rs_out        = rs_q;
  assign bus.Rt_out        = rt_q;
  assign bus.Rd_out        = rd_q;
  assign bus.Valid_out     = valid_q;
endmodule

// File: doc/id_ex_register.md
ID_EX_REGISTER -- requirements
Module: id_ex_register

Interface
REQ-001 Parameter DATA_W, default 32, width of PC+4, register-read and immediate datapaths.
REQ-002 Parameter CNT_W, default 16, width of hazard-event counter.
REQ-003 Clk  input  1  rising-edge clock, sole clock domain.
REQ-004 Rst  input  1  reset, asynchronous, active-high.
REQ-005 Stall  input  1  hold all stage contents.
REQ-006 Flush  input  1  load bubble (branch/jump squash).
REQ-007 EX_in  input  9  [8:7] shsb, [6:3] ALUOp, [2] ALUSrc, [1:0] RegDst.
REQ-008 M_in  input  5  [4] Branch, [3] MemRead, [2] MemWrite, [1] specBranch, [0] BNE.
REQ-009 WB_in  input  4  [3] lblh, [2:1] MemtoReg, [0] RegWrite.
REQ-010 PCPlus4_in, ReadData1_in, ReadData2_in, Imm_in  input  DATA_W each  decode-stage datapath values.
REQ-011 Rs_in, Rt_in, Rd_in  input  5 each  register specifiers of the instruction in decode.
REQ-012 EX_out 9, M_out 5, WB_out 4, PCPlus4_out/ReadData1_out/ReadData2_out/Imm_out DATA_W, Rs_out/Rt_out/Rd_out 5  outputs  registered copies.
REQ-013 Valid_out  output  1  stage holds a real instruction.
REQ-014 HazardStall  output  1  load-use hazard; upstream PC and IF/ID SHALL hold (present only with HAZARD_DETECT_EN).
REQ-015 HazardCount  output  CNT_W  saturating count of hazard bubbles (present only with HAZARD_DETECT_EN).

Function
REQ-016 All outputs SHALL update only on rising Clk; latency input to output exactly one cycle.
REQ-017 Per-edge priority SHALL be: Rst > Flush > Stall > HazardStall bubble > normal load.
REQ-018 Normal load: every *_out <= *_in, Valid_out <= 1.
REQ-019 Stall=1 (Flush=0): all registers including Valid_out and HazardCount SHALL hold.
REQ-020 Bubble (Flush=1, or HazardStall=1 with Stall=0): EX_out, M_out, WB_out, Rs/Rt/Rd_out, datapath outputs SHALL load 0; Valid_out <= 0.
REQ-021 Flush and Stall both high: Flush wins; bubble loaded.
REQ-022 Don't-care (X) bits on EX_in/M_in/WB_in SHALL pass through unchanged on normal load; bubbles SHALL never contain X.
REQ-023 HazardStall SHALL be combinational: Valid_out & M_out[3] & (Rt_out != 0) & (Rt_out == Rs_in | Rt_out == Rt_in).
REQ-024 Because the bubble clears Valid_out, HazardStall SHALL last exactly one cycle per load-use pair.
REQ-025 HazardCount SHALL increment by 1 on each edge loading a hazard bubble; saturate at all-ones; no wrap.

Reset
REQ-026 Rst=1 SHALL immediately, independent of Clk, force all outputs to 0 (Valid_out=0, HazardStall=0, HazardCount=0).
REQ-027 Reset asserted mid-stall or mid-hazard SHALL discard the held instruction; first edge after release performs normal-load rules.

Configuration
REQ-028 Macro HAZARD_DETECT_EN defined: load-use detector, HazardStall, HazardCount and REQ-023..025 compiled in.
REQ-029 Macro undefined: ports HazardStall/HazardCount absent; priority reduces to Rst > Flush > Stall > load.

Structure
REQ-030 Package id_ex_pkg SHALL hold EX/M/WB widths, bit-index constants (M_MEMREAD=3, WB_REGWRITE=0, etc.) and bubble constants EX_NOP/M_NOP/WB_NOP=0.
REQ-031 Sub-module load_use_detect SHALL contain REQ-023 logic and the saturating counter; instantiated only under HAZARD_DETECT_EN.

Verification
REQ-032 Rst pulse mid-cycle with outputs nonzero -> all outputs 0 before next edge.
REQ-033 EX_in=9'h009, M_in=0, WB_in=4'h3, Rd_in=5 (R-type) -> next edge EX_out=9'h009, WB_out=4'h3, Rd_out=5, Valid_out=1.
REQ-034 Stall=1 for 3 cycles with changing inputs -> outputs frozen; Flush=1 with Stall=1 -> bubble, Valid_out=0.
REQ-035 LW (M=5'b01000, Rt=8) followed by decode Rs_in=8 -> HazardStall=1 one cycle, bubble loaded, HazardCount=1, then dependent loaded with Valid_out=1.
REQ-036 LW to Rt=0 followed by Rs_in=0 -> HazardStall stays 0; HazardCount preset near all-ones via repeated hazards -> saturates at 16'hFFFF.
